// File: rtl/keypad_scanner.sv
// keypad_scanner: sweeps a 4x4 key matrix column by column, debounces full scans
// and reports single-key presses as a 4-bit code with a one-cycle strobe.
module keypad_scanner #(
  parameter logic [31:0] SCAN_TICKS     = 32'd50,
  parameter int          DEBOUNCE_SCANS = 4
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic [3:0] i_rows,
  output logic [3:0] o_cols,
  output logic [3:0] o_key_code,
  output logic       o_key_valid,
  output logic       o_key_down
);
  localparam int TW = $clog2(SCAN_TICKS);
  localparam int MW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [4:0] NONE = 5'h10;
  typedef enum logic {IDLE, PRESSED} state_t;
  state_t        r_state;
  logic [3:0]    r_rows_s1, r_rows_s2;
  logic [TW-1:0] r_tick;
  logic [1:0]    r_col;
  logic [11:0]   r_snap;
  logic [4:0]    r_prev;
  logic [MW-1:0] r_match;
  logic [3:0]    r_key_code;
  logic          r_key_valid, r_key_down;
  logic          w_last, w_eval, w_acc;
  logic [15:0]   w_full;
  logic [4:0]    w_ones, w_cand;
  logic [MW-1:0] w_match_nxt;
  assign o_cols      = ~(4'b0001 << r_col);
  assign o_key_code  = r_key_code;
  assign o_key_valid = r_key_valid;
  assign o_key_down  = r_key_down;
  assign w_last      = r_tick == TW'(SCAN_TICKS - 32'd1);
  assign w_eval      = w_last && r_col == 2'd3;
  // column 3 is sampled on the very cycle the scan is evaluated, so use it live
  assign w_full      = {~r_rows_s2, r_snap};
  always_comb begin
    w_ones = '0;
    w_cand = NONE;
    for (int i = 0; i < 16; i++)
      if (w_full[i]) begin
        w_ones = w_ones + 5'd1;
        w_cand = {1'b0, 4'(i)};
      end
    if (w_ones != 5'd1) w_cand = NONE;
  end
  assign w_match_nxt = (w_cand != r_prev) ? MW'(1) :
                       (r_match == MW'(DEBOUNCE_SCANS)) ? r_match : r_match + 1'b1;
  assign w_acc = w_eval && w_match_nxt == MW'(DEBOUNCE_SCANS);
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rows_s1 <= 4'hF;
      r_rows_s2 <= 4'hF;
      r_tick    <= '0;
      r_col     <= '0;
      r_snap    <= '0;
      r_prev    <= NONE;
      r_match   <= '0;
    end else begin
      r_rows_s1 <= i_rows;
      r_rows_s2 <= r_rows_s1;
      r_tick    <= w_last ? '0 : r_tick + 1'b1;
      r_col     <= w_last ? r_col + 2'd1 : r_col;
      for (int k = 0; k < 3; k++)
        if (w_last && r_col == 2'(k)) r_snap[k*4 +: 4] <= ~r_rows_s2;
      if (w_eval) begin
        r_prev  <= w_cand;
        r_match <= w_match_nxt;
      end
    end
  end
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_acc && !w_cand[4] && (r_state == IDLE || w_cand[3:0] != r_key_code)) begin
        r_state     <= PRESSED;
        r_key_code  <= w_cand[3:0];
        r_key_valid <= 1'b1;
        r_key_down  <= 1'b1;
      end else if (w_acc && w_cand[4]) begin
        r_state    <= IDLE;
        r_key_down <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a simulated 4x4 key matrix and checks debounced key
// reports against table vectors, corner-case sequences and a mask-level model.
module tb_keypad_scanner;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] rows, cols, key_code;
  logic       key_valid, key_down;
  logic [15:0] pressed = '0;
  int errors = 0, checks = 0, pulses = 0, mon_bad = 0;
  logic prev_v = 1'b0;

  keypad_scanner #(.SCAN_TICKS(32'd50), .DEBOUNCE_SCANS(4)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_rows(rows), .o_cols(cols),
    .o_key_code(key_code), .o_key_valid(key_valid), .o_key_down(key_down));

  always #5 clk = ~clk;

  // a pressed key {c,r} shorts row r to column c while that column is driven low
  always_comb begin
    rows = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[c*4+r] && !cols[c]) rows[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid) pulses++;
    if (key_valid && prev_v) mon_bad++;
    if ($countones(~cols) != 1) mon_bad++;
    prev_v = key_valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic [15:0] m, input int n, output int np);
    int p0;
    pressed = m;
    p0 = pulses;
    repeat (n) @(negedge clk);
    np = pulses - p0;
  endtask

  typedef struct {
    logic [15:0] mask;
    int          pulses;
    logic [3:0]  code;
    logic        down;
  } vec_t;
  vec_t vecs[9];

  initial begin
    int np, cnt, p0, sweep_bad;
    logic [3:0] m_code;
    logic m_down;
    vecs[0] = '{16'h0000, 0, 4'h0, 1'b0};
    vecs[1] = '{16'h0200, 1, 4'h9, 1'b1};
    vecs[2] = '{16'h0000, 0, 4'h9, 1'b0};
    vecs[3] = '{16'h0021, 0, 4'h9, 1'b0};
    vecs[4] = '{16'h0001, 1, 4'h0, 1'b1};
    vecs[5] = '{16'h0008, 1, 4'h3, 1'b1};
    vecs[6] = '{16'h1008, 0, 4'h3, 1'b0};
    vecs[7] = '{16'h8000, 1, 4'hF, 1'b1};
    vecs[8] = '{16'h0000, 0, 4'hF, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_cols", 32'(cols), 32'he);
    chk("reset_code", 32'(key_code), 32'h0);
    chk("reset_valid", 32'(key_valid), 32'h0);
    chk("reset_down", 32'(key_down), 32'h0);
    rst_n = 1'b1;
    sweep_bad = 0;
    for (int k = 0; k < 400; k++) begin
      if (cols !== ~(4'b0001 << ((k / 50) % 4))) sweep_bad++;
      @(negedge clk);
    end
    chk("sweep_bad_samples", 32'(sweep_bad), 32'h0);

    for (int i = 0; i < 9; i++) begin
      hold(vecs[i].mask, 1100, np);
      chk($sformatf("vec%0d_pulses", i), 32'(np), 32'(vecs[i].pulses));
      chk($sformatf("vec%0d_code", i), 32'(key_code), 32'(vecs[i].code));
      chk($sformatf("vec%0d_down", i), 32'(key_down), 32'(vecs[i].down));
    end

    pressed = 16'h0200;
    p0 = pulses;
    cnt = 0;
    while (pulses == p0 && cnt < 1003) begin
      @(negedge clk);
      cnt++;
    end
    chk("press_within_1003", 32'(pulses != p0), 32'h1);
    chk("press_code", 32'(key_code), 32'h9);
    hold(16'h0200, 600, np);
    chk("held_no_repeat", 32'(np), 32'h0);
    chk("held_down", 32'(key_down), 32'h1);

    pressed = 16'h0000;
    p0 = pulses;
    cnt = 0;
    while (key_down && cnt < 1003) begin
      @(negedge clk);
      cnt++;
    end
    chk("release_within_1003", 32'(key_down), 32'h0);
    chk("release_no_pulse", 32'(pulses - p0), 32'h0);
    chk("release_code_held", 32'(key_code), 32'h9);
    hold(16'h0000, 400, np);

    p0 = pulses;
    for (int t = 0; t < 20; t++) begin
      pressed = (t % 2 == 0) ? 16'h0200 : 16'h0000;
      repeat (30) @(negedge clk);
    end
    hold(16'h0200, 1100, np);
    chk("bounce_one_pulse", 32'(pulses - p0), 32'h1);
    chk("bounce_code", 32'(key_code), 32'h9);

    #2 rst_n = 1'b0;
    #1;
    chk("midreset_cols", 32'(cols), 32'he);
    chk("midreset_code", 32'(key_code), 32'h0);
    chk("midreset_down", 32'(key_down), 32'h0);
    chk("midreset_valid", 32'(key_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    hold(16'h0200, 1100, np);
    chk("after_reset_pulses", 32'(np), 32'h1);
    chk("after_reset_code", 32'(key_code), 32'h9);

    m_code = 4'h9;
    m_down = 1'b1;
    for (int s = 0; s < 12; s++) begin
      logic [15:0] m;
      int kind, a, b, exp_p;
      kind = $urandom_range(0, 2);
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      m = (kind == 0) ? 16'h0 : (kind == 1) ? 16'(1 << a) : 16'((1 << a) | (1 << b));
      exp_p = 0;
      if ($countones(m) != 1) m_down = 1'b0;
      else if (!m_down || m_code != 4'(a)) begin
        exp_p = 1;
        m_code = 4'(a);
        m_down = 1'b1;
      end
      hold(m, 1100 + $urandom_range(0, 199), np);
      chk($sformatf("rand%0d_pulses mask=%04h", s, m), 32'(np), 32'(exp_p));
      chk($sformatf("rand%0d_code", s), 32'(key_code), 32'(m_code));
      chk($sformatf("rand%0d_down", s), 32'(key_down), 32'(m_down));
    end

    chk("monitor_cols_and_double_pulse", 32'(mon_bad), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
